// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key-expansion sequencer with round-key file and registered read port.
// Define KEY_SCHED_ABORT_EN to add an abort input that cancels a running expansion.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS      = 10,
    parameter int STEPS_PER_ROUND = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef KEY_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [127:0] ke_key_o,
    output logic [3:0]   ke_round_o,
    output logic [2:0]   ke_cnt_o,
    input  logic [127:0] ke_round_key_i,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data
);
    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [127:0] rk [NUM_ROUNDS+1];
    logic kill, last_step, last_round, accept, wr_en;
`ifdef KEY_SCHED_ABORT_EN
    assign kill = abort & busy;
`else
    assign kill = 1'b0;
`endif
    assign busy       = state == LOAD || state == EXPAND || state == WRITE;
    assign done       = state == DONE;
    assign last_step  = ke_cnt_o == 3'(STEPS_PER_ROUND - 1);
    assign last_round = ke_round_o == 4'(NUM_ROUNDS);
    assign accept     = state == IDLE && start;
    assign wr_en      = state == WRITE && !kill;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = EXPAND;
            EXPAND:  state_nx = last_step ? WRITE : EXPAND;
            WRITE:   state_nx = last_round ? DONE : EXPAND;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    // round/cnt double as the datapath control outputs and hold outside an expansion
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ke_key_o   <= '0;
            ke_round_o <= '0;
            ke_cnt_o   <= '0;
            keys_valid <= 1'b0;
        end else begin
            if (accept) begin
                ke_key_o   <= key_in;
                ke_round_o <= '0;
                ke_cnt_o   <= '0;
                keys_valid <= 1'b0;
            end
            if (state == LOAD) begin
                ke_round_o <= 4'd1;
                ke_cnt_o   <= '0;
            end
            if (state == EXPAND && !last_step) ke_cnt_o <= ke_cnt_o + 3'd1;
            if (wr_en && !last_round) begin
                ke_round_o <= ke_round_o + 4'd1;
                ke_cnt_o   <= '0;
            end
            if (done) keys_valid <= 1'b1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
            rk_rd_data <= '0;
        end else begin
            if (state == LOAD) rk[0] <= ke_key_o;
            if (wr_en) rk[ke_round_o] <= ke_round_key_i;
            rk_rd_data <= (rk_rd_addr > 4'(NUM_ROUNDS)) ? '0 : rk[rk_rd_addr];
        end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed bench for the key-schedule sequencer and its round-key file.
module tb_aes_key_sched_ctrl;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
    } rd_vec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
    logic [127:0] key_in = '0, key2 = '0;
    logic [3:0] rk_rd_addr = '0, rk2_addr = 4'd10;
    logic busy, done, keys_valid, busy2, done2, kv2;
    logic [127:0] ke_key_o, ke_round_key_i, rk_rd_data, key2_o, rk2_in, rd2_data;
    logic [3:0] ke_round_o, round2;
    logic [2:0] ke_cnt_o, cnt2;
`ifdef KEY_SCHED_ABORT_EN
    logic abort = 1'b0;
`endif
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign ke_round_key_i = {28'h0, ke_round_o, 96'h0};
    assign rk2_in         = {28'h0, round2, 96'h0};

    aes_key_sched_ctrl dut (
        .clk(clk), .rst_n(rst_n),
`ifdef KEY_SCHED_ABORT_EN
        .abort(abort),
`endif
        .start(start), .key_in(key_in), .busy(busy), .done(done), .keys_valid(keys_valid),
        .ke_key_o(ke_key_o), .ke_round_o(ke_round_o), .ke_cnt_o(ke_cnt_o),
        .ke_round_key_i(ke_round_key_i), .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data)
    );

    aes_key_sched_ctrl #(.STEPS_PER_ROUND(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
`ifdef KEY_SCHED_ABORT_EN
        .abort(abort),
`endif
        .start(start2), .key_in(key2), .busy(busy2), .done(done2), .keys_valid(kv2),
        .ke_key_o(key2_o), .ke_round_o(round2), .ke_cnt_o(cnt2),
        .ke_round_key_i(rk2_in), .rk_rd_addr(rk2_addr), .rk_rd_data(rd2_data)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // called at a negedge; start is sampled on the following posedge (edge T), sample i precedes edge T+i
    task automatic run(input logic [127:0] k, input int release_at, input int poke_at, input int max_k,
                       output int n_done, output int first_done, output int last_done,
                       output int n_busy, output int n_kv, output logic [127:0] rd_k2, output logic [127:0] rd_k3);
        n_done = 0; first_done = 0; last_done = 0; n_busy = 0; n_kv = 0; rd_k2 = '0; rd_k3 = '0;
        key_in = k;
        start = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= max_k; i++) begin
            if (done) begin
                n_done++;
                last_done = i;
                if (first_done == 0) first_done = i;
            end
            if (busy) n_busy++;
            if (keys_valid) n_kv++;
            if (i == 2) rd_k2 = rk_rd_data;
            if (i == 3) rd_k3 = rk_rd_data;
            if (i == 1) begin
                check("load_round", ke_round_o, 0);
                check("load_cnt", ke_cnt_o, 0);
            end else if (i <= 51 && (i - 2) % 5 < 4) begin
                check("expand_cnt", ke_cnt_o, (i - 2) % 5);
                check("expand_round", ke_round_o, 1 + (i - 2) / 5);
            end
            start = (i < release_at) || (i == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rd_vec_t tbl [13];
        int nd, fd, ld, nb, nk, cmax;
        logic [127:0] r2, r3;
        tbl[0] = '{4'd0, K1};
        for (int r = 1; r <= 10; r++) tbl[r] = '{4'(r), {28'h0, 4'(r), 96'h0}};
        tbl[11] = '{4'd11, '0};
        tbl[12] = '{4'd15, '0};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_kv", keys_valid, 0);
        check("rst_key", ke_key_o, 0);
        check("rst_round", ke_round_o, 0);
        check("rst_cnt", ke_cnt_o, 0);
        check("rst_rd", rk_rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // first schedule, stray start in EXPAND at sample 20
        run(K1, 1, 20, 60, nd, fd, ld, nb, nk, r2, r3);
        check("e1_ndone", nd, 1);
        check("e1_done_at", fd, 52);
        check("e1_busy", nb, 51);
        check("e1_kv", nk, 8);
        check("e1_rd_old", r2, 0);
        check("e1_rd_new", r3, K1);
        check("e1_key_o", ke_key_o, K1);
        for (int i = 0; i < 13; i++) begin
            rk_rd_addr = tbl[i].addr;
            @(negedge clk);
            check($sformatf("rd_addr%0d", tbl[i].addr), rk_rd_data, tbl[i].exp);
        end

        // second schedule, start poked while in DONE
        rk_rd_addr = '0;
        run(K2, 1, 52, 60, nd, fd, ld, nb, nk, r2, r3);
        check("e2_ndone", nd, 1);
        check("e2_done_at", fd, 52);
        check("e2_busy", nb, 51);
        check("e2_kv", nk, 8);
        check("e2_rd_prev", r2, K1);
        check("e2_rd_new", r3, K2);

        // start held high restarts from the IDLE cycle after DONE
        run(K1, 54, 0, 110, nd, fd, ld, nb, nk, r2, r3);
        check("hold_ndone", nd, 2);
        check("hold_first", fd, 52);
        check("hold_last", ld, 105);
        check("hold_busy", nb, 102);
        check("hold_kv", nk, 6);

        // reset mid-expansion
        key_in = K2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_kv", keys_valid, 0);
        check("mid_done", done, 0);
        check("mid_key", ke_key_o, 0);
        check("mid_round", ke_round_o, 0);
        check("mid_rd", rk_rd_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("mid_no_done", nd, 0);
        for (int a = 0; a <= 10; a++) begin
            rk_rd_addr = 4'(a);
            @(negedge clk);
            check($sformatf("mid_rd%0d", a), rk_rd_data, 0);
        end

`ifdef KEY_SCHED_ABORT_EN
        key_in = K1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 0);
        nd = 0;
        nk = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) nd++;
            if (keys_valid) nk++;
            @(negedge clk);
        end
        check("ab_no_done", nd, 0);
        check("ab_kv", nk, 0);
        for (int i = 0; i <= 10; i++) begin
            rk_rd_addr = tbl[i].addr;
            @(negedge clk);
            check($sformatf("ab_rd%0d", i), rk_rd_data, (i <= 2) ? tbl[i].exp : '0);
        end
`endif

        // two-step rounds
        key2 = K2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        nd = 0; fd = 0; nb = 0; cmax = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done2) begin
                nd++;
                if (fd == 0) fd = i;
            end
            if (busy2) nb++;
            if (busy2 && int'(cnt2) > cmax) cmax = int'(cnt2);
            @(negedge clk);
        end
        check("s2_ndone", nd, 1);
        check("s2_done_at", fd, 32);
        check("s2_busy", nb, 31);
        check("s2_cnt_max", cmax, 1);
        check("s2_kv", kv2, 1);
        check("s2_key_o", key2_o, K2);
        check("s2_rd10", rd2_data, {28'h0, 4'd10, 96'h0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencer for the single-round AES-128 key expansion datapath.
- On a start request it loads the cipher key into the datapath at round 0.
- It steps the datapath through NUM_ROUNDS rounds, each of STEPS_PER_ROUND sub-cycles, and captures every round key into an internal round-key file.
- The file is then read by the cipher round engine through a registered read port.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds (AES-128); round-key file depth = NUM_ROUNDS+1
STEPS_PER_ROUND, 4, sub-steps per round driven on ke_cnt (range 1..8)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request new expansion; sampled only in IDLE
key_in  input  128  cipher key; captured on accepted start
busy  output  1  expansion in progress
done  output  1  one-cycle pulse when all round keys stored
keys_valid  output  1  round-key file holds a complete schedule
ke_key_o  output  128  key to datapath key_in (held from capture)
ke_round_o  output  4  round number to datapath
ke_cnt_o  output  3  sub-step to datapath
ke_round_key_i  input  128  round key from datapath
rk_rd_addr  input  4  round-key read address
rk_rd_data  output  128  registered round-key read data

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, done, keys_valid = 0.
  - ke_key_o, ke_round_o, ke_cnt_o = 0.
  - rk_rd_data = 0; all round-key file entries = 0.
- States: IDLE, LOAD, EXPAND, WRITE, DONE.
- IDLE:
  - start=1 -> capture key_in into ke_key_o, clear keys_valid, go LOAD.
  - start=0 -> stay.
- LOAD (1 cycle): ke_round_o=0, ke_cnt_o=0; write key_in copy to rk[0]; go EXPAND with round=1, cnt=0.
- EXPAND:
  - ke_round_o = current round, ke_cnt_o = cnt.
  - cnt increments each cycle.
  - When cnt == STEPS_PER_ROUND-1, go WRITE next cycle.
- WRITE (1 cycle): rk[round] <= ke_round_key_i.
  - round == NUM_ROUNDS -> go DONE.
  - Otherwise round+1, cnt=0, go EXPAND.
- DONE (1 cycle): done=1, keys_valid set to 1, go IDLE.
- busy = 1 in LOAD, EXPAND and WRITE; 0 in IDLE and DONE.
- Latency: start sampled at edge T -> LOAD at T+1 -> rk[r] written at T+1+r*(STEPS_PER_ROUND+1) -> done high at T+2+NUM_ROUNDS*(STEPS_PER_ROUND+1). Defaults: T+52.
- start while busy or in DONE: ignored, no queuing.
- start held high continuously: restarts expansion from the IDLE cycle after DONE.
- ke_round_o/ke_cnt_o hold their last values in IDLE and DONE.
- Read port:
  - rk_rd_data <= rk[rk_rd_addr] each cycle (1-cycle latency), independent of state.
  - Address > NUM_ROUNDS returns 0.
  - Read of an entry written in the same cycle returns the old value.
- Entries from a previous schedule remain readable during a new expansion until overwritten; keys_valid=0 during that time.
- Reset mid-operation: immediate return to reset values, file cleared, no done pulse.

Optional Feature:
KEY_SCHED_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD, EXPAND or WRITE -> next state IDLE, busy=0, no done pulse, keys_valid stays 0.
  - Partially written file entries are retained.
  - abort has priority over the WRITE in the same cycle (no write).
  - abort in IDLE or DONE has no effect.
- Undefined: no abort port; an expansion always runs to DONE.

Test Plan:
- Reset then start with key_in=128'h2b7e151628aed2a6abf7158809cf4f3c -> done pulse exactly 52 cycles after start edge; busy high 51 cycles; keys_valid=1; rk[0] reads back the key one cycle after addr=0.
- Stub datapath returning {28'h0, round, 96'h0} -> rk[r] read back matches for r=1..10; ke_cnt_o cycles 0,1,2,3 in every round; rk_rd_addr=11 -> 0.
- Assert start again at cycle 20 of an expansion -> ignored; single done at cycle 52; second start after done -> second done 52 cycles later; keys_valid low in between.
- Drop rst_n at cycle 30 -> busy, keys_valid=0 at once; all rk reads return 0; no done.
- With KEY_SCHED_ABORT_EN, abort at cycle 15 -> IDLE next cycle, no done; rk[1..2] written, rk[3..10] still 0; keys_valid=0.
- Parameter STEPS_PER_ROUND=2, NUM_ROUNDS=10 -> done at T+32; ke_cnt_o only 0,1.
